embcpu8k_pio_seq: RTL



---
 rtl/embcpu8k_pio_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/embcpu8k_pio_seq.sv
// Avalon-MM pattern sequencer: plays a table of {value, hold} entries onto an 8-bit port.
// Optional done interrupt (IRQMASK at address 4, irq port) enabled by EMBCPU8K_PIO_SEQ_IRQ_EN.
module embcpu8k_pio_seq #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned HOLD_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  out_port
`ifdef EMBCPU8K_PIO_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [2:0] LastIdx = 3'(DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic [7:0]          out_q, out_d;
    logic                loop_q, loop_d;
    logic [2:0]          len_q, len_d;
    logic                done_q, done_d;
    logic [7:0]          idleval_q, idleval_d;
    logic [7:0]          val_q  [8];
    logic [7:0]          val_d  [8];
    logic [HOLD_W-1:0]   hold_q [8];
    logic [HOLD_W-1:0]   hold_d [8];

    logic       wr, wr_ctrl, wr_len, wr_status, wr_idle, wr_entry;
    logic       start_req, stop_req, entry_sel, done_set, busy;
    logic [2:0] nxt_idx;
    logic       unused_wd;

    assign unused_wd = ^writedata;

    assign wr        = chipselect & ~write_n;
    // Only addresses 8..8+DEPTH-1 map to entries; DEPTH is a power of two.
    assign entry_sel = address[3] && ((address[2:0] & ~LastIdx) == 3'd0);
    assign wr_ctrl   = wr && (address == 4'd0);
    assign wr_len    = wr && (address == 4'd1);
    assign wr_status = wr && (address == 4'd2);
    assign wr_idle   = wr && (address == 4'd3);
    assign wr_entry  = wr && entry_sel;
    assign stop_req  = wr_ctrl && writedata[2];
    assign start_req = wr_ctrl && writedata[0] && !writedata[2];
    assign busy      = (state_q == StRun);
    assign nxt_idx   = idx_q + 3'd1;

    always_comb begin
        loop_d    = loop_q;
        len_d     = len_q;
        idleval_d = idleval_q;
        for (int i = 0; i < 8; i++) begin
            val_d[i]  = val_q[i];
            hold_d[i] = hold_q[i];
        end
        if (wr_ctrl) loop_d = writedata[1];
        if (wr_len)  len_d = (writedata[2:0] > LastIdx) ? LastIdx : writedata[2:0];
        if (wr_idle) idleval_d = writedata[7:0];
        if (wr_entry) begin
            val_d[address[2:0]]  = writedata[7:0];
            hold_d[address[2:0]] = writedata[8 +: HOLD_W];
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        done_set = 1'b0;
        if (stop_req) begin
            state_d = StIdle;
            idx_d   = 3'd0;
            cnt_d   = '0;
        end else if (state_q == StIdle) begin
            if (start_req) begin
                state_d = StRun;
                idx_d   = 3'd0;
                out_d   = val_q[0];
                cnt_d   = hold_q[0];
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - HOLD_W'(1);
        end else if (idx_q < len_q) begin
            idx_d = nxt_idx;
            out_d = val_q[nxt_idx];
            cnt_d = hold_q[nxt_idx];
        end else if (loop_q) begin
            idx_d = 3'd0;
            out_d = val_q[0];
            cnt_d = hold_q[0];
        end else begin
            state_d  = StIdle;
            idx_d    = 3'd0;
            done_set = 1'b1;
        end
        // A completion in the same cycle as a clear leaves DONE set.
        done_d = done_q;
        if (wr_status && writedata[0]) done_d = 1'b0;
        if (done_set) done_d = 1'b1;
    end

`ifdef EMBCPU8K_PIO_SEQ_IRQ_EN
    logic irqmask_q, irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (wr && (address == 4'd4)) irqmask_q <= writedata[0];
            irq_q <= done_q & irqmask_q;
        end
    end

    assign irq = irq_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= 3'd0;
            cnt_q     <= '0;
            out_q     <= 8'd0;
            loop_q    <= 1'b0;
            len_q     <= 3'd0;
            done_q    <= 1'b0;
            idleval_q <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                val_q[i]  <= 8'd0;
                hold_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            loop_q    <= loop_d;
            len_q     <= len_d;
            done_q    <= done_d;
            idleval_q <= idleval_d;
            for (int i = 0; i < 8; i++) begin
                val_q[i]  <= val_d[i];
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign out_port = busy ? out_q : idleval_q;

    always_comb begin
        readdata = 32'd0;
        case (address)
            4'd0: readdata = {21'd0, idx_q, 6'd0, loop_q, busy};
            4'd1: readdata = {29'd0, len_q};
            4'd2: readdata = {31'd0, done_q};
            4'd3: readdata = {24'd0, idleval_q};
`ifdef EMBCPU8K_PIO_SEQ_IRQ_EN
            4'd4: readdata = {31'd0, irqmask_q};
`endif
            default: begin
                if (entry_sel) begin
                    readdata[7:0]        = val_q[address[2:0]];
                    readdata[8 +: HOLD_W] = hold_q[address[2:0]];
                end
            end
        endcase
    end

endmodule
